// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode handshake carrying {instr, pc}.
interface fetch_queue_if #(
  parameter int WIDTH  = 15,
  parameter int ADDR_W = 15
);
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - issue PC, one-deep ROM request tracker and prefetch FIFO.
// FETCH_PERF_EN adds a saturating decode-bubble counter; otherwise bubble_count is 0.
module fetch_queue #(
  parameter int                WIDTH    = 15,
  parameter int                ADDR_W   = 15,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'('o4000)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_en,
  output logic [ADDR_W-1:0]      ROM_address,
  input  logic [WIDTH-1:0]       ROM_read_data,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  fetch_queue_if.master          dec,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            bubble_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]       issue_pc_q, issue_pc_d;
  logic [ADDR_W-1:0]       inflight_pc_q, inflight_pc_d;
  logic                    inflight_q, inflight_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [WIDTH+ADDR_W-1:0] mem_q [DEPTH];
  logic [WIDTH+ADDR_W-1:0] head;
  logic [CNT_W:0]          occ;
  logic                    push, pop, issue;

  assign push = inflight_q;
  assign pop  = dec.out_valid & dec.out_ready;
  // Credit counts the in-flight word so the ROM never returns data the FIFO cannot hold.
  assign occ   = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue = fetch_en & ~redirect & (occ < (CNT_W+1)'(DEPTH));

  always_comb begin
    issue_pc_d    = issue_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? issue_pc_q : inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      issue_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) issue_pc_d = issue_pc_q + ADDR_W'(1);
      if (push)  wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      issue_pc_q    <= issue_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if (!redirect) assert (!(push && !pop && count_q == CNT_W'(DEPTH)));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !redirect && push) mem_q[wr_ptr_q] <= {ROM_read_data, inflight_pc_q};
  end

  assign head          = mem_q[rd_ptr_q];
  assign dec.out_valid = (count_q != '0);
  assign dec.out_instr = dec.out_valid ? head[WIDTH+ADDR_W-1:ADDR_W] : '0;
  assign dec.out_pc    = dec.out_valid ? head[ADDR_W-1:0] : '0;
  assign ROM_address   = issue_pc_q;
  assign count         = count_q;

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_q;
  always_ff @(posedge clock) begin
    if (reset) bubble_q <= '0;
    else if (dec.out_ready && !dec.out_valid && !redirect && bubble_q != '1)
      bubble_q <= bubble_q + 32'd1;
  end
  assign bubble_count = bubble_q;
`else
  assign bubble_count = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - table vectors plus a pc/instr scoreboard for fetch_queue.
module tb_fetch_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [14:0] redirect_pc = '0;
  logic [14:0] ROM_address;
  logic [14:0] rom_q = '0;
  logic [2:0]  count;
  logic [31:0] bubble_count;
  int          vectors = 0;
  int          miscompares = 0;
  bit          sb_en = 1'b0;
  logic [14:0] exp_q [$];

  fetch_queue_if #(.WIDTH(15), .ADDR_W(15)) dq ();

  fetch_queue #(.WIDTH(15), .ADDR_W(15), .DEPTH(4), .RESET_PC(15'o4000)) dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .ROM_address(ROM_address),
    .ROM_read_data(rom_q), .redirect(redirect), .redirect_pc(redirect_pc),
    .dec(dq), .count(count), .bubble_count(bubble_count)
  );

  always #5 clock = ~clock;

  function automatic logic [14:0] rom_fn(input logic [14:0] a);
    return a ^ 15'o52525;
  endfunction

  // Synchronous ROM: data for the address of cycle t is presented in cycle t+1.
  always @(posedge clock) rom_q <= rom_fn(ROM_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb_en && !reset && dq.out_valid && dq.out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", 32'(dq.out_pc) + 32'h10000, 32'(dq.out_pc));
      else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", 32'(dq.out_pc), 32'(e));
        chk("sb_instr", 32'(dq.out_instr), 32'(rom_fn(e)));
      end
    end
  end

  typedef struct {
    bit          rst;
    bit          fe;
    bit          rdy;
    logic [14:0] addr;
    bit          v;
    logic [2:0]  cnt;
    logic [14:0] pc;
  } vec_t;
  vec_t vecs [$];

  task automatic add(input bit rst, input bit fe, input bit rdy, input logic [14:0] addr,
                     input bit v, input logic [2:0] cnt, input logic [14:0] pc);
    vec_t x;
    x.rst = rst; x.fe = fe; x.rdy = rdy; x.addr = addr; x.v = v; x.cnt = cnt; x.pc = pc;
    vecs.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_sb(input string name);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) cyc();
    if (exp_q.size() != 0) begin
      chk(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    sb_en = 1'b0;
    dq.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] b0;
    bit          drained;
    dq.out_ready = 1'b0;

    // Reset release, free-running decode.
    add(1, 1, 1, 15'o4000, 0, 3'd0, 15'o0);
    add(0, 1, 1, 15'o4001, 0, 3'd0, 15'o0);
    add(0, 1, 1, 15'o4002, 1, 3'd1, 15'o4000);
    add(0, 1, 1, 15'o4003, 1, 3'd1, 15'o4001);
    add(0, 1, 1, 15'o4004, 1, 3'd1, 15'o4002);
    // Decode stalled: FIFO fills to DEPTH and issue stops.
    add(1, 1, 0, 15'o4000, 0, 3'd0, 15'o0);
    add(0, 1, 0, 15'o4001, 0, 3'd0, 15'o0);
    add(0, 1, 0, 15'o4002, 1, 3'd1, 15'o4000);
    add(0, 1, 0, 15'o4003, 1, 3'd2, 15'o4000);
    add(0, 1, 0, 15'o4004, 1, 3'd3, 15'o4000);
    for (int k = 0; k < 5; k++) add(0, 1, 0, 15'o4004, 1, 3'd4, 15'o4000);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      fetch_en = vecs[i].fe;
      dq.out_ready = vecs[i].rdy;
      @(negedge clock);
      chk($sformatf("vec%0d_addr", i), 32'(ROM_address), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_valid", i), 32'(dq.out_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_pc", i), 32'(dq.out_pc), 32'(vecs[i].pc));
      chk($sformatf("vec%0d_instr", i), 32'(dq.out_instr),
          vecs[i].v ? 32'(rom_fn(vecs[i].pc)) : 32'd0);
      if (vecs[i].rst) chk($sformatf("vec%0d_bubble", i), bubble_count, 32'd0);
      cyc();
    end

    // Release the stall: every prefetched word appears once, in order.
    for (int k = 0; k < 8; k++) exp_q.push_back(15'o4000 + 15'(k));
    sb_en = 1'b1;
    dq.out_ready = 1'b1;
    wait_sb("stall_release_drain");

    // Redirect with three words queued and one in flight.
    do_reset();
    fetch_en = 1'b1;
    dq.out_ready = 1'b0;
    repeat (4) cyc();
    redirect = 1'b1;
    redirect_pc = 15'o1234;
    @(negedge clock);
    chk("redir_pre_count", 32'(count), 32'd3);
    cyc();
    redirect = 1'b0;
    dq.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(15'o1234 + 15'(k));
    sb_en = 1'b1;
    @(negedge clock);
    chk("redir_t1_count", 32'(count), 32'd0);
    chk("redir_t1_addr", 32'(ROM_address), 32'(15'o1234));
    chk("redir_t1_valid", 32'(dq.out_valid), 32'd0);
    cyc();
    @(negedge clock);
    chk("redir_t2_valid", 32'(dq.out_valid), 32'd0);
    cyc();
    @(negedge clock);
    chk("redir_t3_valid", 32'(dq.out_valid), 32'd1);
    chk("redir_t3_pc", 32'(dq.out_pc), 32'(15'o1234));
    cyc();
    wait_sb("redir_drain");

    // Issue PC wraps from 'o77777 to 0.
    do_reset();
    fetch_en = 1'b1;
    dq.out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 15'o77776;
    cyc();
    redirect = 1'b0;
    exp_q.push_back(15'o77776);
    exp_q.push_back(15'o77777);
    exp_q.push_back(15'o00000);
    exp_q.push_back(15'o00001);
    sb_en = 1'b1;
    wait_sb("wrap_drain");

    // Reset while the FIFO is full.
    do_reset();
    fetch_en = 1'b1;
    dq.out_ready = 1'b0;
    repeat (8) cyc();
    @(negedge clock);
    chk("full_count", 32'(count), 32'd4);
    chk("full_valid", 32'(dq.out_valid), 32'd1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_valid", 32'(dq.out_valid), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_addr", 32'(ROM_address), 32'(15'o4000));
    chk("rst_mid_pc", 32'(dq.out_pc), 32'd0);
    chk("rst_mid_instr", 32'(dq.out_instr), 32'd0);
    chk("rst_mid_bubble", bubble_count, 32'd0);

    // Bubble counter over five empty cycles with decode ready.
    cyc();
    dq.out_ready = 1'b1;
    repeat (6) cyc();
    fetch_en = 1'b0;
    drained = 1'b0;
    for (int n = 0; n < 20 && !drained; n++) begin
      @(negedge clock);
      if (!dq.out_valid) drained = 1'b1;
      else cyc();
    end
    chk("perf_drained", 32'(drained), 32'd1);
    b0 = bubble_count;
    repeat (5) @(negedge clock);
    chk("perf_still_empty", 32'(dq.out_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_bubble_delta", bubble_count - b0, 32'd5);
`else
    chk("perf_bubble_b0", b0, 32'd0);
    chk("perf_bubble_b1", bubble_count, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
